// File: rtl/vmem_pkg.sv
// Shared definitions for the vector/scalar data-buffer sequencer.
// Holds the state encoding, default geometry and the lane width.
package vmem_pkg;

  localparam int unsigned VMEM_LANES  = 16;
  localparam int unsigned VMEM_ADDR_W = 18;
  localparam int unsigned LANE_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vmem_seq_if.sv
// Request/response bus between a requester and the vmem_seq sequencer.
interface vmem_seq_if
  import vmem_pkg::*;
#(
  parameter int unsigned LANES = VMEM_LANES
);

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic                      req_vec;
  logic [31:0]               req_addr;
  logic [LANE_W-1:0]         req_wdata_s;
  logic [LANE_W*LANES-1:0]   req_wdata_v;
  logic                      resp_valid;
  logic [LANE_W-1:0]         resp_rdata_s;
  logic [LANE_W*LANES-1:0]   resp_rdata_v;

  modport master (
    output req_valid, req_write, req_vec, req_addr, req_wdata_s, req_wdata_v,
    input  req_ready, resp_valid, resp_rdata_s, resp_rdata_v
  );

  modport slave (
    input  req_valid, req_write, req_vec, req_addr, req_wdata_s, req_wdata_v,
    output req_ready, resp_valid, resp_rdata_s, resp_rdata_v
  );

endinterface

// File: rtl/vmem_lane_buf.sv
// Vector result register with per-lane capture, plus a lane-select mux
// used to pick the next store lane out of a latched vector.
module vmem_lane_buf
  import vmem_pkg::*;
#(
  parameter  int unsigned LANES = VMEM_LANES,
  localparam int unsigned IDX_W = idx_width(LANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_lane,
  input  logic [LANE_W-1:0]       wr_data,
  output logic [LANE_W*LANES-1:0] q,
  input  logic [LANE_W*LANES-1:0] sel_vec,
  input  logic [IDX_W-1:0]        sel_idx,
  output logic [LANE_W-1:0]       sel_data
);

  logic [LANE_W*LANES-1:0] buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wr_en && (wr_lane == IDX_W'(i))) begin
        buf_d[i*LANE_W +: LANE_W] = wr_data;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_data = sel_vec[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign q = buf_q;

endmodule

// File: rtl/vmem_seq.sv
// Sequences one scalar or LANES-wide vector load/store per request onto a
// 16-bit synchronous data buffer, one element per cycle.
module vmem_seq
  import vmem_pkg::*;
#(
  parameter int unsigned LANES  = VMEM_LANES,
  parameter int unsigned ADDR_W = VMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  vmem_seq_if.slave         bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANE_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [LANE_W-1:0] mem_q
);

  localparam int unsigned IDX_W = idx_width(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  state_e                  state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [LANE_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic                    mem_wren_q, mem_wren_d;
  logic                    write_q, write_d;
  logic                    vec_q, vec_d;
  logic [LANE_W*LANES-1:0] wdata_v_q, wdata_v_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    cap_en_q, cap_en_d;
  logic [IDX_W-1:0]        cap_idx_q, cap_idx_d;
  logic [LANE_W-1:0]       rdata_s_q, rdata_s_d;

  logic [IDX_W-1:0]        next_idx;
  logic [LANE_W-1:0]       next_lane_wdata;

  assign next_idx = idx_q + IDX_W'(1);

  generate
    if (ADDR_W < 32) begin : g_addr_unused
      // Upper element-address bits are deliberately ignored.
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];
    end
  endgenerate

  // Read data for the element addressed in the previous cycle arrives now,
  // so captures trail the address stream by one cycle (hence DRAIN on loads).
  vmem_lane_buf #(
    .LANES (LANES)
  ) u_lane_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (cap_en_q && vec_q),
    .wr_lane  (cap_idx_q),
    .wr_data  (mem_q),
    .q        (bus.resp_rdata_v),
    .sel_vec  (wdata_v_q),
    .sel_idx  (next_idx),
    .sel_data (next_lane_wdata)
  );

  assign rdata_s_d = (cap_en_q && !vec_q) ? mem_q : rdata_s_q;

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wren_d   = 1'b0;
    write_d      = write_q;
    vec_d        = vec_q;
    wdata_v_d    = wdata_v_q;
    idx_d        = idx_q;
    cap_en_d     = 1'b0;
    cap_idx_d    = cap_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d     = ST_ACCESS;
          req_ready_d = 1'b0;
          write_d     = bus.req_write;
          vec_d       = bus.req_vec;
          wdata_v_d   = bus.req_wdata_v;
          idx_d       = '0;
          mem_addr_d  = bus.req_addr[ADDR_W-1:0];
          mem_wren_d  = bus.req_write;
          mem_wdata_d = bus.req_vec ? bus.req_wdata_v[LANE_W-1:0] : bus.req_wdata_s;
        end
      end
      ST_ACCESS: begin
        cap_en_d  = !write_q;
        cap_idx_d = idx_q;
        if (vec_q && (idx_q != LAST_IDX)) begin
          idx_d       = next_idx;
          mem_addr_d  = mem_addr_q + ADDR_W'(1);
          mem_wdata_d = next_lane_wdata;
          mem_wren_d  = write_q;
        end else begin
          state_d      = write_q ? ST_DONE : ST_DRAIN;
          resp_valid_d = write_q;
        end
      end
      ST_DRAIN: begin
        state_d      = ST_DONE;
        resp_valid_d = 1'b1;
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wren_q   <= 1'b0;
      write_q      <= 1'b0;
      vec_q        <= 1'b0;
      wdata_v_q    <= '0;
      idx_q        <= '0;
      cap_en_q     <= 1'b0;
      cap_idx_q    <= '0;
      rdata_s_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wren_q   <= mem_wren_d;
      write_q      <= write_d;
      vec_q        <= vec_d;
      wdata_v_q    <= wdata_v_d;
      idx_q        <= idx_d;
      cap_en_q     <= cap_en_d;
      cap_idx_q    <= cap_idx_d;
      rdata_s_q    <= rdata_s_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata_s = rdata_s_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign mem_wren         = mem_wren_q;

endmodule

// File: doc/vmem_seq.md
VMEM_SEQ -- requirements
Module: vmem_seq

Interface
REQ-001 SHALL have parameter LANES, default 16, number of 16-bit lanes per vector.
REQ-002 SHALL have parameter ADDR_W, default 18, width of the scalar data-buffer address.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
REQ-007 SHALL have port req_write  in  1  1=store, 0=load.
REQ-008 SHALL have port req_vec  in  1  1=vector (LANES elements), 0=scalar.
REQ-009 SHALL have port req_addr  in  32  element address; only bits [ADDR_W-1:0] are used.
REQ-010 SHALL have port req_wdata_s  in  16  scalar store data.
REQ-011 SHALL have port req_wdata_v  in  16*LANES  vector store data; lane i = bits [16i+15:16i].
REQ-012 SHALL have port resp_valid  out  1  one-cycle completion pulse, loads and stores.
REQ-013 SHALL have port resp_rdata_s  out  16  scalar load result.
REQ-014 SHALL have port resp_rdata_v  out  16*LANES  vector load result.
REQ-015 SHALL have port mem_addr  out  ADDR_W  data-buffer address.
REQ-016 SHALL have port mem_wdata  out  16  data-buffer write data.
REQ-017 SHALL have port mem_wren  out  1  data-buffer write enable.
REQ-018 SHALL have port mem_q  in  16  data-buffer read data, valid the cycle after mem_addr is presented.

Function
REQ-019 SHALL implement FSM IDLE, ACCESS, DRAIN, DONE; req_ready=1 only in IDLE.
REQ-020 SHALL, on acceptance (edge E0), latch the whole request; go IDLE->ACCESS.
REQ-021 SHALL, in ACCESS, drive mem_addr = (base + k) mod 2^ADDR_W for k = 0..N-1, one element per cycle; N=1 scalar, N=LANES vector.
REQ-022 SHALL, for stores, assert mem_wren in every ACCESS cycle, mem_wdata = req_wdata_s or lane k; mem_wren=0 in all other states.
REQ-023 SHALL go ACCESS->DONE after the last element for stores, ACCESS->DRAIN for loads; DRAIN lasts one cycle, then DONE.
REQ-024 SHALL capture mem_q for element k at the edge after k's address cycle, into resp_rdata_s (scalar) or lane k of resp_rdata_v (vector).
REQ-025 SHALL assert resp_valid for exactly the DONE cycle, then return to IDLE.
REQ-026 SHALL meet these latencies in cycles after E0: scalar store resp at 2; scalar load resp at 3; vector store mem_wren cycles 1..16 and resp at 17; vector load resp at 18.
REQ-027 SHALL hold resp_rdata_s/v stable from DONE until the next load's capture; stores leave them unchanged.
REQ-028 SHALL ignore req_valid outside IDLE; no queueing.
REQ-029 SHALL wrap the address counter at 2^ADDR_W, with no error flag.

Reset
REQ-030 SHALL, on rst_n low, immediately (asynchronously) enter IDLE with req_ready=1 and resp_valid=0, mem_wren=0, mem_addr=0, mem_wdata=0, and resp_rdata_s/v=0.
REQ-031 SHALL abort an in-flight request on reset; elements already written stay written and no resp_valid is issued.

Structure
REQ-032 SHALL take the state enum, LANES, ADDR_W default and lane width 16 from shared package vmem_pkg.
REQ-033 SHALL place lane capture/select in one sub-module, vmem_lane_buf: a 16*LANES register with per-lane write and a lane-select mux.

Verification
REQ-034 Scalar store addr 0x00010, data 0xBEEF -> mem_wren for one cycle at 0x00010; resp_valid at cycle 2; a load of 0x00010 returns 0xBEEF at cycle 3.
REQ-035 Vector store base 0x00100, lane i = 0x1000+i -> 16 consecutive writes 0x00100..0x0010F; resp at 17; a vector load returns the identical 256 bits at 18.
REQ-036 Vector load base 0x3FFF8 -> addresses 0x3FFF8..0x3FFFF, then 0x00000..0x00007; lane 8 = content of 0x00000.
REQ-037 req_valid held high through a vector load -> only one acceptance; req_ready low cycles 1..18; second request accepted at first IDLE cycle.
REQ-038 rst_n low at cycle 5 of a vector store -> mem_wren drops without a clock edge; only lanes 0..3 written; no resp_valid; req_ready=1.
